ram_arbiter: RTL and testbench

- Shares the single 256x4 data RAM between the CPU datapath and a host/debug port (loader, monitor, single-step probe).
- Sits between the CPU's RAM address/data/write signals and the RAM instance. Owns the RAM address, write data and write-enable.
- CPU has default priority. A starvation counter bounds host wait time. A lock counter bounds host burst length.

---
 rtl/ram_arbiter_pkg.sv | 26 ++
 rtl/ram_arbiter_if.sv | 56 +++++
 rtl/ram_arbiter_sat_counter.sv | 48 ++++
 rtl/ram_arbiter.sv | 174 +++++++++++++++++
 tb/tb_ram_arbiter.sv | 391 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_arbiter_pkg.sv
// ============================================================================
// Module : ram_arbiter_pkg
// Brief  : State encoding and RAM geometry shared by the arbiter, RAM and PC.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ram_arbiter_pkg;

    localparam int RAM_AW = 8;
    localparam int RAM_DW = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CPU  = 2'd1,
        HOST = 2'd2
    } arb_state_e;

    // Bits needed to hold 0..limit inclusive.
    function automatic int cnt_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ram_arbiter_if.sv
// ============================================================================
// Module : ram_arbiter_if
// Brief  : CPU, host and RAM-side signals of the RAM arbiter.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ram_arbiter_if
    import ram_arbiter_pkg::*;
();

    logic              cpu_req;
    logic              cpu_we;
    logic [RAM_AW-1:0] cpu_addr;
    logic [RAM_DW-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_stall;
    logic [RAM_DW-1:0] cpu_rdata;

    logic              host_req;
    logic              host_we;
    logic [RAM_AW-1:0] host_addr;
    logic [RAM_DW-1:0] host_wdata;
    logic              host_lock;
    logic              host_gnt;
    logic [RAM_DW-1:0] host_rdata;
    logic              host_rvalid;

    logic [RAM_AW-1:0] ram_addr;
    logic [RAM_DW-1:0] ram_wdata;
    logic              ram_we;
    logic [RAM_DW-1:0] ram_rdata;

    // Arbiter side.
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_stall, cpu_rdata,
        input  host_req, host_we, host_addr, host_wdata, host_lock,
        output host_gnt, host_rdata, host_rvalid,
        output ram_addr, ram_wdata, ram_we,
        input  ram_rdata
    );

    // Requester / RAM side.
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_stall, cpu_rdata,
        output host_req, host_we, host_addr, host_wdata, host_lock,
        input  host_gnt, host_rdata, host_rvalid,
        input  ram_addr, ram_wdata, ram_we,
        output ram_rdata
    );

endinterface

`default_nettype wire

// File: rtl/ram_arbiter_sat_counter.sv
// ============================================================================
// Module : sat_counter
// Brief  : Saturating up-counter with synchronous clear and at-limit flag.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter #(
    parameter int WIDTH = 3,
    parameter int LIMIT = 4
) (
    input  wire              clk,
    input  wire              rst,
    input  wire              i_inc,
    input  wire              i_clr,
    output logic [WIDTH-1:0] o_count,
    output logic             o_at_limit
);

    localparam logic [WIDTH-1:0] C_LIMIT = WIDTH'(LIMIT);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Clear wins over increment.
    always_comb begin
        count_d = count_q;
        if (i_clr) begin
            count_d = '0;
        end else if (i_inc && (count_q != C_LIMIT)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_count    = count_q;
    assign o_at_limit = (count_q == C_LIMIT);

endmodule

`default_nettype wire

// File: rtl/ram_arbiter.sv
// ============================================================================
// Module : ram_arbiter
// Brief  : Shares the 256x4 data RAM between the CPU and the host/debug port.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int LOCK_MAX     = 8
) (
    input  wire          clk,
    input  wire          reset,
    ram_arbiter_if.slave arb
);

    localparam int C_SW = cnt_width(STARVE_LIMIT);
    localparam int C_LW = cnt_width(LOCK_MAX);
    // Decision is made during the transfer that would be burst item lock_cnt+1.
    localparam logic [C_LW-1:0] C_LOCK_LAST = C_LW'(LOCK_MAX - 1);

    arb_state_e        state_q;
    arb_state_e        state_d;
    arb_state_e        w_idle_next;
    logic [RAM_DW-1:0] host_rdata_q;
    logic [RAM_DW-1:0] host_rdata_d;
    logic              host_rvalid_q;
    logic              host_rvalid_d;

    logic              w_cpu_gnt;
    logic              w_host_gnt;
    logic              w_host_xfer;
    logic              w_starved;
    logic              w_lock_room;
    logic              w_leave_host;
    logic              w_starve_inc;
    logic              w_starve_clr;
    logic              w_starve_at_limit;
    logic [C_SW-1:0]   w_starve_cnt;
    logic              w_lock_inc;
    logic              w_lock_clr;
    logic              w_lock_at_limit;
    logic [C_LW-1:0]   w_lock_cnt;
    logic              w_unused;

    assign w_cpu_gnt    = (state_q == CPU);
    assign w_host_gnt   = (state_q == HOST);
    assign w_host_xfer  = arb.host_req & w_host_gnt;

    assign w_starve_inc = arb.host_req & ~w_host_gnt;
    assign w_starve_clr = ~arb.host_req | w_host_xfer;
    assign w_starved    = arb.host_req & w_starve_at_limit;

    assign w_lock_room  = (w_lock_cnt < C_LOCK_LAST);
    assign w_leave_host = w_host_gnt & (state_d != HOST);
    assign w_lock_inc   = w_host_xfer & arb.host_lock;
    assign w_lock_clr   = ~arb.host_lock | w_leave_host;

    assign w_unused     = &{1'b0, w_starve_cnt, w_lock_at_limit};

    sat_counter #(
        .WIDTH (C_SW),
        .LIMIT (STARVE_LIMIT)
    ) u_starve_cnt (
        .clk        (clk),
        .rst        (reset),
        .i_inc      (w_starve_inc),
        .i_clr      (w_starve_clr),
        .o_count    (w_starve_cnt),
        .o_at_limit (w_starve_at_limit)
    );

    sat_counter #(
        .WIDTH (C_LW),
        .LIMIT (LOCK_MAX)
    ) u_lock_cnt (
        .clk        (clk),
        .rst        (reset),
        .i_inc      (w_lock_inc),
        .i_clr      (w_lock_clr),
        .o_count    (w_lock_cnt),
        .o_at_limit (w_lock_at_limit)
    );

    always_comb begin
        w_idle_next = IDLE;
        if (arb.host_req && (w_starved || !arb.cpu_req)) begin
            w_idle_next = HOST;
        end else if (arb.cpu_req) begin
            w_idle_next = CPU;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: state_d = w_idle_next;
            CPU: begin
                if (w_starved) begin
                    state_d = HOST;
                end else if (!arb.cpu_req) begin
                    state_d = w_idle_next;
                end
            end
            HOST: begin
                if (arb.host_req && arb.host_lock && (w_lock_room || !arb.cpu_req)) begin
                    state_d = HOST;
                end else if (arb.cpu_req) begin
                    state_d = CPU;
                end else if (arb.host_req) begin
                    state_d = HOST;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        arb.ram_addr  = '0;
        arb.ram_wdata = '0;
        arb.ram_we    = 1'b0;
        unique case (state_q)
            CPU: begin
                arb.ram_addr  = arb.cpu_addr;
                arb.ram_wdata = arb.cpu_wdata;
                arb.ram_we    = arb.cpu_req & arb.cpu_we;
            end
            HOST: begin
                arb.ram_addr  = arb.host_addr;
                arb.ram_wdata = arb.host_wdata;
                arb.ram_we    = arb.host_req & arb.host_we;
            end
            default: ;
        endcase
        // A reset edge must never commit a write.
        if (reset) begin
            arb.ram_we = 1'b0;
        end
    end

    always_comb begin
        host_rdata_d  = host_rdata_q;
        host_rvalid_d = w_host_xfer & ~arb.host_we;
        if (host_rvalid_d) begin
            host_rdata_d = arb.ram_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            host_rdata_q  <= '0;
            host_rvalid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            host_rdata_q  <= host_rdata_d;
            host_rvalid_q <= host_rvalid_d;
        end
    end

    assign arb.cpu_gnt     = w_cpu_gnt;
    assign arb.cpu_stall   = arb.cpu_req & ~w_cpu_gnt;
    assign arb.cpu_rdata   = arb.ram_rdata;
    assign arb.host_gnt    = w_host_gnt;
    assign arb.host_rdata  = host_rdata_q;
    assign arb.host_rvalid = host_rvalid_q;

endmodule

`default_nettype wire

// File: tb/tb_ram_arbiter.sv
// ============================================================================
// Module : tb_ram_arbiter
// Brief  : Self-checking bench for ram_arbiter with a behavioural 256x4 RAM.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_arbiter;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ram_arbiter_if bus ();

    ram_arbiter #(
        .STARVE_LIMIT (4),
        .LOCK_MAX     (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .arb   (bus)
    );

    logic [3:0] mem [256];
    always @(posedge clk) begin
        if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    end
    assign bus.ram_rdata = mem[bus.ram_addr];

    logic [3:0] ref_mem [256];
    logic [3:0] exp_q [$];
    logic [3:0] sb_exp;
    int n_tests = 0;
    int n_fail  = 0;

    // Host read scoreboard: one expected nibble per host read transfer.
    always @(negedge clk) begin
        if (bus.host_rvalid === 1'b1) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL rvalid_unexpected: host_rvalid=1 host_rdata=%h, required no rvalid", bus.host_rdata);
            end else begin
                sb_exp = exp_q.pop_front();
                if (bus.host_rdata !== sb_exp) begin
                    n_fail++;
                    $display("FAIL host_rdata: got %h required %h", bus.host_rdata, sb_exp);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.cpu_req  = 1'b1;
        bus.host_req = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_tests++;
            if ({bus.cpu_gnt, bus.host_gnt} !== 2'b00) begin
                n_fail++;
                $display("FAIL reset_gnt: cycle %0d cpu/host gnt=%b required 00", i, {bus.cpu_gnt, bus.host_gnt});
            end
            n_tests++;
            if (bus.ram_we !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_ram_we: cycle %0d got %b required 0", i, bus.ram_we);
            end
            n_tests++;
            if (bus.host_rvalid !== 1'b0 || bus.host_rdata !== 4'h0) begin
                n_fail++;
                $display("FAIL reset_host_rd: cycle %0d rvalid=%b rdata=%h required 0/0", i, bus.host_rvalid, bus.host_rdata);
            end
        end
        reset = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({bus.cpu_gnt, bus.host_gnt} !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_first_gnt: cpu/host gnt=%b required 10", {bus.cpu_gnt, bus.host_gnt});
        end
        step();
        bus.host_req = 1'b0;
    endtask

    task automatic test_cpu_only();
        int we_cnt    = 0;
        int stall_cnt = 0;
        bus.cpu_we    = 1'b1;
        bus.cpu_addr  = 8'h10;
        bus.cpu_wdata = 4'hA;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.ram_we === 1'b1) we_cnt++;
            if (bus.cpu_stall !== 1'b0) stall_cnt++;
            if (i < 2) begin
                n_tests++;
                if (bus.cpu_gnt !== 1'b1) begin
                    n_fail++;
                    $display("FAIL cpu_gnt: cycle %0d got %b required 1", i, bus.cpu_gnt);
                end
            end
            if (i == 1) begin
                n_tests++;
                if (bus.cpu_rdata !== ref_mem[8'h10]) begin
                    n_fail++;
                    $display("FAIL cpu_rdata: got %h required %h", bus.cpu_rdata, ref_mem[8'h10]);
                end
            end
            @(posedge clk);
            if (i == 0) ref_mem[8'h10] = 4'hA;
            #1;
            if (i == 0) bus.cpu_we = 1'b0;
            if (i == 1) bus.cpu_req = 1'b0;
        end
        n_tests++;
        if (we_cnt != 1) begin
            n_fail++;
            $display("FAIL cpu_we_pulses: got %0d required 1", we_cnt);
        end
        n_tests++;
        if (stall_cnt != 0) begin
            n_fail++;
            $display("FAIL cpu_stall: high %0d cycles required 0", stall_cnt);
        end
    endtask

    task automatic test_starve();
        bit ok = 1'b0;
        int gnt_at = -1;
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 8'h10;
        for (int w = 0; w < 20; w++) begin
            @(negedge clk);
            if (bus.cpu_gnt === 1'b1) begin ok = 1'b1; break; end
        end
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL starve_cpu_wait: cpu_gnt=0 after 20 cycles required 1");
        end
        step();
        bus.host_req  = 1'b1;
        bus.host_we   = 1'b0;
        bus.host_lock = 1'b0;
        bus.host_addr = 8'h10;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (bus.host_gnt === 1'b1) begin gnt_at = k; break; end
            step();
        end
        n_tests++;
        if (gnt_at != 6) begin
            n_fail++;
            $display("FAIL starve_gnt_cycle: host_gnt on cycle %0d required 6", gnt_at);
        end
        if (gnt_at > 0) begin
            @(posedge clk);
            exp_q.push_back(ref_mem[8'h10]);
            #1;
        end
        bus.host_req = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({bus.cpu_gnt, bus.host_gnt} !== 2'b10) begin
            n_fail++;
            $display("FAIL starve_back_to_cpu: cpu/host gnt=%b required 10", {bus.cpu_gnt, bus.host_gnt});
        end
        step();
    endtask

    task automatic test_lock_burst();
        bit g, prev = 1'b0;
        int sent = 0, nruns = 0, run_a = 0, run_b = 0, between = 0, stall_a = 0;
        bus.cpu_req    = 1'b1;
        bus.host_req   = 1'b1;
        bus.host_lock  = 1'b1;
        bus.host_we    = 1'b1;
        bus.host_addr  = 8'h40;
        bus.host_wdata = 4'h0;
        for (int c = 0; c < 80 && sent < 12; c++) begin
            @(negedge clk);
            g = bus.host_gnt;
            if (g) begin
                if (!prev) nruns++;
                if (nruns == 1) begin
                    run_a++;
                    if (bus.cpu_stall === 1'b1) stall_a++;
                end else if (nruns == 2) begin
                    run_b++;
                end
            end else if (nruns == 1 && bus.cpu_gnt === 1'b1) begin
                between++;
            end
            prev = g;
            @(posedge clk);
            if (g) begin
                ref_mem[8'(8'h40 + sent)] = 4'(sent);
                sent++;
            end
            #1;
            if (sent == 12) begin
                bus.host_req  = 1'b0;
                bus.host_lock = 1'b0;
            end else begin
                bus.host_addr  = 8'(8'h40 + sent);
                bus.host_wdata = 4'(sent);
            end
        end
        bus.host_req  = 1'b0;
        bus.host_lock = 1'b0;
        n_tests++;
        if (sent != 12) begin
            n_fail++;
            $display("FAIL lock_timeout: %0d transfers done required 12", sent);
        end
        n_tests++;
        if (run_a != 8 || stall_a != 8) begin
            n_fail++;
            $display("FAIL lock_first_run: len=%0d stall=%0d required 8/8", run_a, stall_a);
        end
        n_tests++;
        if (between < 1) begin
            n_fail++;
            $display("FAIL lock_cpu_between: cpu grants %0d required >=1", between);
        end
        n_tests++;
        if (nruns != 2 || run_b != 4) begin
            n_fail++;
            $display("FAIL lock_second_run: runs=%0d len=%0d required 2/4", nruns, run_b);
        end
        bus.cpu_req = 1'b0;
        repeat (3) step();
    endtask

    task automatic test_host_reads();
        logic [63:0] rv_hist = '0;
        int t = 0, t_first = -1, idx = 0;
        bit g;
        bus.cpu_req    = 1'b0;
        bus.host_req   = 1'b1;
        bus.host_lock  = 1'b0;
        bus.host_we    = 1'b1;
        bus.host_addr  = 8'h00;
        bus.host_wdata = 4'h1;
        for (int c = 0; c < 40 && idx < 8; c++) begin
            @(negedge clk);
            g = bus.host_gnt;
            rv_hist[t] = bus.host_rvalid;
            if (g && idx == 4) t_first = t;
            t++;
            @(posedge clk);
            if (g) begin
                if (idx < 4) ref_mem[idx] = 4'(idx + 1);
                else exp_q.push_back(ref_mem[idx - 4]);
                idx++;
            end
            #1;
            if (idx < 4) begin
                bus.host_addr  = 8'(idx);
                bus.host_wdata = 4'(idx + 1);
            end else if (idx < 8) begin
                bus.host_we   = 1'b0;
                bus.host_addr = 8'(idx - 4);
            end else begin
                bus.host_req = 1'b0;
            end
        end
        bus.host_req = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            rv_hist[t] = bus.host_rvalid;
            t++;
        end
        n_tests++;
        if (idx != 8 || t_first < 0) begin
            n_fail++;
            $display("FAIL host_rd_timeout: %0d transfers done required 8", idx);
        end else begin
            n_tests++;
            if (rv_hist[t_first +: 6] !== 6'b011110) begin
                n_fail++;
                $display("FAIL host_rvalid_run: pattern %b required 011110", rv_hist[t_first +: 6]);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok = 1'b0;
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b1;
        bus.cpu_addr  = 8'h20;
        bus.cpu_wdata = 4'h3;
        for (int w = 0; w < 20; w++) begin
            @(negedge clk);
            if (bus.cpu_gnt === 1'b1) begin ok = 1'b1; break; end
        end
        @(posedge clk);
        if (ok) ref_mem[8'h20] = 4'h3;
        #1;
        bus.cpu_req = 1'b0;
        bus.cpu_we  = 1'b0;
        repeat (2) step();
        bus.host_req   = 1'b1;
        bus.host_we    = 1'b1;
        bus.host_lock  = 1'b0;
        bus.host_addr  = 8'h20;
        bus.host_wdata = 4'h5;
        ok = 1'b0;
        for (int w = 0; w < 20; w++) begin
            @(negedge clk);
            if (bus.host_gnt === 1'b1) begin ok = 1'b1; break; end
        end
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL rstmid_host_wait: host_gnt=0 after 20 cycles required 1");
        end
        reset = 1'b1;
        #1;
        n_tests++;
        if (bus.ram_we !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_ram_we: got %b required 0", bus.ram_we);
        end
        step();
        bus.host_req = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({bus.cpu_gnt, bus.host_gnt, bus.host_rvalid} !== 3'b000) begin
            n_fail++;
            $display("FAIL rstmid_idle: cpu/host gnt,rvalid=%b required 000",
                     {bus.cpu_gnt, bus.host_gnt, bus.host_rvalid});
        end
        reset = 1'b0;
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 8'h20;
        ok = 1'b0;
        for (int w = 0; w < 20; w++) begin
            @(negedge clk);
            if (bus.cpu_gnt === 1'b1) begin ok = 1'b1; break; end
        end
        n_tests++;
        if (!ok || bus.cpu_rdata !== ref_mem[8'h20]) begin
            n_fail++;
            $display("FAIL rstmid_ram_kept: gnt=%b RAM[20]=%h required gnt 1 data %h",
                     ok, bus.cpu_rdata, ref_mem[8'h20]);
        end
        step();
        bus.cpu_req = 1'b0;
        repeat (2) step();
    endtask

    initial begin
        bus.cpu_req    = 1'b0;
        bus.cpu_we     = 1'b0;
        bus.cpu_addr   = 8'h00;
        bus.cpu_wdata  = 4'h0;
        bus.host_req   = 1'b0;
        bus.host_we    = 1'b0;
        bus.host_addr  = 8'h00;
        bus.host_wdata = 4'h0;
        bus.host_lock  = 1'b0;

        test_reset();
        test_cpu_only();
        test_starve();
        test_lock_burst();
        test_host_reads();
        test_reset_mid();

        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL rvalid_missing: %0d host reads without rvalid required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
